// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared saturation helpers for the NPU datapath.
//   sat_max(w)            : largest signed value representable in w bits
//   sat_min(w)            : smallest signed value representable in w bits
//   sat_clip(v, w, sat_en): {ovf, result}; result is clipped to [min,max] when
//                           sat_en=1 and v is out of range, otherwise v itself
//                           (caller keeps the low w bits for wrap behaviour)
// All values are carried at MAXW bits so one function serves any data width.
// -----------------------------------------------------------------------------
package npu_pkg;

    localparam int MAXW = 64;

    function automatic logic signed [MAXW-1:0] sat_max(input int w);
        logic signed [MAXW-1:0] one;
        one = 1;
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [MAXW-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

    function automatic logic [MAXW:0] sat_clip(input logic signed [MAXW-1:0] v,
                                               input int w,
                                               input logic sat_en);
        logic                   ovf;
        logic signed [MAXW-1:0] r;
        ovf = (v > sat_max(w)) || (v < sat_min(w));
        r   = v;
        if (ovf && sat_en)
            r = (v < 0) ? sat_min(w) : sat_max(w);
        return {ovf, r};
    endfunction

endpackage

// File: rtl/sat_add_w.sv
// -----------------------------------------------------------------------------
// sat_add_w
// Combinational saturating adder: res = clip(sext(a) + b) to WIDTH bits.
//   i_a      [WIDTH-1:0]  signed accumulator operand
//   i_b      [SUM_W-1:0]  signed lane-sum operand (wider than WIDTH)
//   i_sat_en              1 = clamp to MIN/MAX on overflow, 0 = wrap
//   o_res    [WIDTH-1:0]  result
//   o_ovf                 exact sum falls outside the WIDTH-bit range
// -----------------------------------------------------------------------------
module sat_add_w
    import npu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SUM_W = 19
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [SUM_W-1:0] i_b,
    input  logic             i_sat_en,
    output logic [WIDTH-1:0] o_res,
    output logic             o_ovf
);

    // Range limits held at the full sum width so the compare is exact.
    localparam logic signed [SUM_W:0] MAX_T = (SUM_W+1)'(sat_max(WIDTH));
    localparam logic signed [SUM_W:0] MIN_T = (SUM_W+1)'(sat_min(WIDTH));

    logic signed [SUM_W:0] w_t;
    logic                  w_ovf;

    // One extra bit over SUM_W: the sum itself can never overflow.
    assign w_t = $signed({{(SUM_W+1-WIDTH){i_a[WIDTH-1]}}, i_a})
               + $signed({i_b[SUM_W-1], i_b});

    assign w_ovf = (w_t > MAX_T) || (w_t < MIN_T);
    assign o_ovf = w_ovf;
    assign o_res = (w_ovf && i_sat_en) ? (w_t[SUM_W] ? MIN_T[WIDTH-1:0] : MAX_T[WIDTH-1:0])
                                       : w_t[WIDTH-1:0];

endmodule

// File: rtl/sat_accum_n.sv
// -----------------------------------------------------------------------------
// sat_accum_n
// Saturating reduce-and-accumulate: each accepted beat's LANES signed lanes are
// summed and added into a running accumulator with per-beat saturation. One
// result per vector (marked by in_last) with a sticky overflow flag.
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_sat_en                 per-beat saturate (1) / wrap (0)
//   i_clear                  synchronous flush of partial vector and output
//   i_in_valid/o_in_ready    input handshake; i_in_data flat lanes, i_in_last
//   o_out_valid/i_out_ready  output handshake; o_out_data result, o_out_sat
// Two stages: lane reduction register, then accumulate/saturate. The whole
// pipe advances only when the output slot is free or being drained.
// -----------------------------------------------------------------------------
module sat_accum_n
    import npu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_sat_en,
    input  logic                   i_clear,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [LANES*WIDTH-1:0] i_in_data,
    input  logic                   i_in_last,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WIDTH-1:0]       o_out_data,
    output logic                   o_out_sat
);

    localparam int SUM_W = WIDTH + $clog2(LANES) + 1;

    logic                    r_s1_valid, r_s1_last, r_s1_sat_en;
    logic [SUM_W-1:0]        r_s1_sum;
    logic [WIDTH-1:0]        r_acc;
    logic                    r_sticky;
    logic                    r_out_valid, r_out_sat;
    logic [WIDTH-1:0]        r_out_data;

    logic                    w_adv, w_accept, w_emit;
    logic [WIDTH-1:0]        w_res;
    logic                    w_ovf, w_sticky_n;
    logic signed [SUM_W-1:0] w_part [LANES+1];

    // Lane reduction as a running chain; SUM_W has headroom so it is exact.
    assign w_part[0] = '0;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_part[gi+1] = w_part[gi] + SUM_W'($signed(i_in_data[gi*WIDTH +: WIDTH]));
    end

    assign w_adv      = !r_out_valid || i_out_ready;
    assign w_accept   = i_in_valid && w_adv;
    assign w_emit     = w_adv && r_s1_valid && r_s1_last;
    assign w_sticky_n = r_sticky | w_ovf;

    sat_add_w #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_add (
        .i_a      (r_acc),
        .i_b      (r_s1_sum),
        .i_sat_en (r_s1_sat_en),
        .o_res    (w_res),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_sat_en <= 1'b0;
            r_s1_sum    <= '0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_sum    <= w_part[LANES];
                    r_s1_last   <= i_in_last;
                    r_s1_sat_en <= i_sat_en;
                end
                if (r_s1_valid) begin
                    if (r_s1_last) begin
                        // Vector done: publish and restart so the next
                        // vector can follow without a bubble.
                        r_out_data <= w_res;
                        r_out_sat  <= w_sticky_n;
                        r_acc      <= '0;
                        r_sticky   <= 1'b0;
                    end else begin
                        r_acc    <= w_res;
                        r_sticky <= w_sticky_n;
                    end
                end
            end
            // A fresh result wins over a same-cycle consume.
            if (w_emit)
                r_out_valid <= 1'b1;
            else if (r_out_valid && i_out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready  = w_adv;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sat   = r_out_sat;

endmodule

// File: tb/tb_sat_accum_n.sv
module tb_sat_accum_n;

    logic        clk = 1'b0;
    logic        rst_n, sat_en, clear, in_valid, in_last, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid, out_sat;
    logic [15:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sat_accum_n #(.WIDTH(16), .LANES(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sat_en    (sat_en),
        .i_clear     (clear),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_sat   (out_sat)
    );

    typedef struct {
        string       name;
        logic [63:0] data;
        logic        sat_en;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present one beat from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [63:0] d, input logic last, input logic se);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = last; sat_en = se;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, compare it, then step past its consume.
    task automatic expect_out(input string nm, input logic [15:0] ed, input logic es);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"},  32'(out_data),  32'(ed));
        chk({nm, "_sat"},   32'(out_sat),   32'(es));
        @(negedge clk);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"pos_sum",   {4{16'h1000}},                       1'b1, 16'h4000, 1'b0};
        vecs[1] = '{"pos_sat",   {4{16'h7000}},                       1'b1, 16'h7FFF, 1'b1};
        vecs[2] = '{"pos_wrap",  {4{16'h7000}},                       1'b0, 16'hC000, 1'b1};
        vecs[3] = '{"neg_sat",   {4{16'h8000}},                       1'b1, 16'h8000, 1'b1};
        vecs[4] = '{"cancel",    {16'h0000, 16'h0000, 16'h0001, 16'hFFFF}, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{"neg_wrap",  {4{16'h8000}},                       1'b0, 16'h0000, 1'b1};
        vecs[6] = '{"max_plus1", {16'h0000, 16'h0000, 16'h0001, 16'h7FFF}, 1'b1, 16'h7FFF, 1'b1};
        vecs[7] = '{"min_m1_wr", {16'h0000, 16'h0000, 16'hFFFF, 16'h8000}, 1'b0, 16'h7FFF, 1'b1};
        vecs[8] = '{"one_lane",  {16'h0000, 16'h0000, 16'h0000, 16'h1234}, 1'b1, 16'h1234, 1'b0};

        rst_n = 1'b0; sat_en = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sat",   32'(out_sat),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-beat vectors with exact 2-cycle latency.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = vecs[i].data; in_last = 1'b1; sat_en = vecs[i].sat_en;
            chk({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[i].name, "_lat1"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[i].name, "_data"},  32'(out_data),  32'(vecs[i].exp_data));
            chk({vecs[i].name, "_sat"},   32'(out_sat),   32'(vecs[i].exp_sat));
            @(negedge clk);
        end

        // Saturate then recover across beats; sticky must clear for next vector.
        send({4{16'h1800}}, 1'b0, 1'b1);
        send({4{16'h1800}}, 1'b0, 1'b1);
        send({4{16'hFC00}}, 1'b1, 1'b1);
        send({4{16'h0004}}, 1'b1, 1'b1);
        expect_out("recover", 16'h6FFF, 1'b1);
        expect_out("after",   16'h0010, 1'b0);

        // Continuous streaming: one beat and one result per cycle.
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                chk($sformatf("stream%0d_valid", c-2), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_data", c-2),  32'(out_data),  32'(4*(c-1)));
            end
            if (c < 4) begin
                chk($sformatf("stream%0d_ready", c), 32'(in_ready), 32'd1);
                in_valid = 1'b1; in_data = {4{16'(c+1)}}; in_last = 1'b1; sat_en = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_end", 32'(out_valid), 32'd0);

        // Backpressure: result held, next beat blocked, released cleanly.
        out_ready = 1'b0;
        send({4{16'h0100}}, 1'b1, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; in_data = {4{16'h0200}}; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'h0400);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_drain", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_data",  32'(out_data),  32'h0800);
        @(negedge clk);
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Reset mid-vector discards partial accumulation.
        send({4{16'h0100}}, 1'b0, 1'b1);
        send({4{16'h0100}}, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_sat",   32'(out_sat),   32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        send({4{16'h0001}}, 1'b1, 1'b1);
        expect_out("post_rst", 16'h0004, 1'b0);

        // Clear drops a held result and the beat presented alongside it.
        out_ready = 1'b0;
        send({4{16'h0100}}, 1'b1, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("clr_held_data", 32'(out_data), 32'h0400);
        clear = 1'b1; in_valid = 1'b1; in_data = {4{16'h0300}}; in_last = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_data",  32'(out_data),  32'd0);
        chk("clr_sat",   32'(out_sat),   32'd0);
        repeat (2) @(negedge clk);
        chk("clr_dropped", 32'(out_valid), 32'd0);

        // Clear mid-vector after an overflowing partial sum.
        send({4{16'h7000}}, 1'b0, 1'b1);
        send({4{16'h7000}}, 1'b0, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        send({4{16'h0001}}, 1'b1, 1'b1);
        expect_out("post_clr", 16'h0004, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sat_accum_n.md
Name: sat_accum_n

Overview:
Parametrised saturating reduce-and-accumulate unit for the NPU datapath. It generalises the team's 16-bit saturating adder to WIDTH bits and LANES parallel inputs. Each accepted beat has its lanes summed and added into a running accumulator, with saturation applied per beat. A result is emitted at each vector boundary (in_last), with a sticky overflow flag and valid/ready handshakes on both sides.
It sits between the MAC array and the activation stage, accumulating dense-layer partial sums.

Parameters:
WIDTH, 16, signed two's-complement data width of each lane and of the result.
LANES, 4, number of parallel input lanes per beat (power of two, >=1).
SUM_W, WIDTH+$clog2(LANES)+1, internal lane-sum width (localparam, not overridable).

Ports:
clk  in  1  Clock; all logic on the rising edge.
rst_n  in  1  Synchronous reset, active-low.
sat_en  in  1  1 = saturate on overflow, 0 = wrap (two's-complement truncation); sampled per beat.
clear  in  1  Synchronous flush: drops the partial vector and any held output.
in_valid  in  1  Input beat valid.
in_ready  out  1  Input beat accepted when in_valid && in_ready.
in_data  in  LANES*WIDTH  Flat lanes; lane i = in_data[i*WIDTH +: WIDTH], signed.
in_last  in  1  Marks the final beat of a vector.
out_valid  out  1  Result valid.
out_ready  in  1  Result consumed when out_valid && out_ready.
out_data  out  WIDTH  Accumulated vector result, signed.
out_sat  out  1  1 if any beat of this vector overflowed (in either mode).

Behaviour:
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_sat=0, accumulator=0, sticky flag=0, stage-1 valid=0. in_ready reads 1 in the cycle after reset. Reset mid-vector discards everything.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv. The whole pipe stalls when adv=0.
- Stage 1 (on accept): lane sum computed at SUM_W bits (sign-extended, exact, no overflow possible). s1_sum, s1_last, s1_sat_en and s1_valid are registered.
- Stage 2 (when adv && s1_valid):
  - t = sext(acc) + s1_sum, computed at SUM_W+1 bits.
  - ovf = t > 2^(WIDTH-1)-1 or t < -2^(WIDTH-1).
  - res = ovf ? (s1_sat_en ? (t<0 ? MIN : MAX) : t[WIDTH-1:0]) : t[WIDTH-1:0].
  - MAX = 0x7FFF and MIN = 0x8000 for WIDTH=16.
  - sticky_n = sticky | ovf.
- If s1_last:
  - out_data<=res, out_sat<=sticky_n, out_valid<=1.
  - acc<=0 and sticky<=0, so back-to-back vectors need no bubble.
- Otherwise: acc<=res, sticky<=sticky_n.
- Output handshake: if out_valid && out_ready and no new result arrives that edge, out_valid<=0. Simultaneous consume and new result loads the new result, and out_valid stays 1.
- Latency: the in_last beat accepted at edge t gives out_valid=1 after edge t+1 (2 cycles). Throughput is 1 beat per cycle when out_ready=1.
- out_data/out_sat are held stable while out_valid && !out_ready.
- A single-beat vector (in_last on its first beat) outputs sat(lane sum).
- clear=1 (priority below rst_n, above everything else): same register effect as reset. Any beat presented in the same cycle is dropped.
- Per-beat saturation is order-dependent (saturate then recover is allowed). The bench model must apply the same per-beat rule.
- FSM: implicit two states per vector, ACCUM (acc live) and EMIT (out_valid held). No other states.

Decomposition:
- npu_pkg: function sat_max(WIDTH), function sat_min(WIDTH), and a sat_clip(value, WIDTH, sat_en) function returning {ovf, result}.
- One sub-module, sat_add_w: combinational WIDTH-parametrised saturating adder. Inputs are a (WIDTH), b (SUM_W) and sat_en; outputs are res and ovf. It is instantiated once in stage 2. The lane-reduction tree stays inline as a generate loop.

Test Plan:
1. WIDTH=16, LANES=4, sat_en=1, one beat of lanes {0x1000 x4} with last=1 -> out_data=0x4000, out_sat=0, out_valid 2 cycles after accept.
2. Lanes {0x7000 x4}, last=1: with sat_en=1 -> 0x7FFF, out_sat=1; with sat_en=0 -> 0xC000, out_sat=1.
3. Lanes {0x8000 x4}, sat_en=1 -> 0x8000, out_sat=1. Lanes {0xFFFF, 0x0001, 0x0000, 0x0000} -> 0x0000, out_sat=0.
4. Three-beat vector with lane sums 0x6000, 0x6000, -0x1000 (each lane 0xFC00) -> accumulator goes 0x6000, 0x7FFF, then out 0x6FFF with out_sat=1. The next vector, lane sum 0x0010, -> 0x0010, out_sat=0 (sticky cleared).
5. Backpressure: hold out_ready=0 after a result -> in_ready=0 and out_data stable for 5 cycles. Release -> next vector's result follows with no lost or duplicated beat. Continuous streaming with out_ready=1 -> one beat per cycle.
6. rst_n=0 for one cycle (or clear=1) mid-vector after 2 beats -> all outputs 0. A following single-beat vector {0x0001 x4} -> 0x0004 with no residue from the aborted vector.
